// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory-stage controller and the data RAM port.
// The controller uses the master modport and the RAM side uses the slave modport.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [DATA_W-1:0] dmem_wdata_o;
  logic              dmem_ack_i;
  logic [DATA_W-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: stalls the pipeline while one load/store runs against the data RAM.
// Optional MEM_TIMEOUT_EN adds an ack-wait counter that aborts a request after TIMEOUT+1 REQ cycles.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_r_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  mem_access_ctrl_if.master dmem,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic              err_q, err_d;
  logic              aligned;

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);
  logic [3:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  assign aligned = (addr_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_en_i && aligned) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = ~mem_r_i;
          state_d = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = 4'd0;
`endif
        end else if (mem_en_i) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        if (dmem.dmem_ack_i) begin
          if (!we_q) begin
            rdata_d = dmem.dmem_rdata_i;
            rvld_d  = 1'b1;
          end
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      // DONE releases the stall for one cycle so the finished instruction leaves MEM.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign stall_o           = ((state_q == IDLE) && mem_en_i && aligned) || (state_q == REQ);
  assign dmem.dmem_req_o   = (state_q == REQ);
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign rdata_o           = rdata_q;
  assign rdata_valid_o     = rvld_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: each access is expanded into a per-cycle timeline of expected outputs
// (issue cycle, REQ cycles, DONE cycle) that one process drives and checks every cycle.
module tb_mem_access_ctrl;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en_i = 1'b0;
  logic        mem_r_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_en_i(mem_en_i), .mem_r_i(mem_r_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .dmem(dmem_bus),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, en, r, ack;
    logic [31:0] addr, wdata, rd;
    bit e_stall, e_req, bus_chk, e_we, e_rvld, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } cyc_t;

  cyc_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int stall_cnt = 0, req_cnt = 0, rvld_cnt = 0, err_cnt = 0, rise_cnt = 0;
  bit prev_req = 1'b0;
  logic [31:0] model_rdata = '0;
  bit pend_rvld = 1'b0, pend_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 0; c.en = 0; c.r = 0; c.ack = 0;
    c.addr = '0; c.wdata = '0; c.rd = '0;
    c.e_stall = 0; c.e_req = 0; c.bus_chk = 0; c.e_we = 0; c.e_rvld = 0; c.e_err = 0;
    c.e_addr = '0; c.e_wdata = '0; c.e_rdata = '0;
    return c;
  endfunction

  // Registered pulses appear in the cycle after the event that caused them.
  task automatic push(input cyc_t c_in);
    cyc_t c;
    c = c_in;
    c.e_rvld = pend_rvld;
    c.e_err = pend_err;
    c.e_rdata = model_rdata;
    pend_rvld = 0;
    pend_err = 0;
    q.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(blank());
  endtask

  // waitn < 0: memory never answers.
  task automatic access(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                        input int waitn, input logic [31:0] rd);
    cyc_t c;
    c = blank();
    c.en = 1; c.r = ld; c.addr = a; c.wdata = wd;
    c.e_stall = 1;
    push(c);
    for (int k = 0; k < 1000; k++) begin
      c.e_req = 1; c.bus_chk = 1; c.e_we = !ld; c.e_addr = a; c.e_wdata = wd;
      c.ack = (k == waitn);
      c.rd = c.ack ? rd : (32'hBAD0_0000 | 32'(k));
      push(c);
      if (c.ack) begin
        if (ld) begin
          model_rdata = rd;
          pend_rvld = 1;
        end
        break;
      end
      if (waitn < 0 && k == TMO) begin
        pend_err = 1;
        break;
      end
    end
    c.ack = 0; c.rd = '0;
    c.e_stall = 0; c.e_req = 0; c.bus_chk = 0;
    push(c);
  endtask

  task automatic reset_cycle(input bit ack, input logic [31:0] rd, input bit rst_v);
    cyc_t c;
    c = blank();
    c.rst = rst_v; c.ack = ack; c.rd = rd;
    c.bus_chk = 1;
    model_rdata = '0;
    pend_rvld = 0;
    pend_err = 0;
    push(c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain cycle=%0d got=%0d expected=0 records left", cyc, q.size());
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    stall_cnt = 0; req_cnt = 0; rvld_cnt = 0; err_cnt = 0; rise_cnt = 0;
  endtask

  // Driver and checker: apply one timeline record per cycle, compare at the falling edge.
  initial begin
    cyc_t cur;
    bit have;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      have = (q.size() != 0);
      if (have) begin
        cur = q.pop_front();
        rst = cur.rst; mem_en_i = cur.en; mem_r_i = cur.r; addr_i = cur.addr; wdata_i = cur.wdata;
        dmem_bus.dmem_ack_i = cur.ack; dmem_bus.dmem_rdata_i = cur.rd;
      end else begin
        rst = 0; mem_en_i = 0; mem_r_i = 0; addr_i = '0; wdata_i = '0;
        dmem_bus.dmem_ack_i = 0; dmem_bus.dmem_rdata_i = '0;
      end
      @(negedge clk);
      if (have) begin
        chk("stall_o", 32'(stall_o), 32'(cur.e_stall));
        chk("dmem_req_o", 32'(dmem_bus.dmem_req_o), 32'(cur.e_req));
        chk("rdata_valid_o", 32'(rdata_valid_o), 32'(cur.e_rvld));
        chk("err_o", 32'(err_o), 32'(cur.e_err));
        chk("rdata_o", rdata_o, cur.e_rdata);
        if (cur.bus_chk) begin
          chk("dmem_we_o", 32'(dmem_bus.dmem_we_o), 32'(cur.e_we));
          chk("dmem_addr_o", dmem_bus.dmem_addr_o, cur.e_addr);
          chk("dmem_wdata_o", dmem_bus.dmem_wdata_o, cur.e_wdata);
        end
        stall_cnt += int'(stall_o);
        req_cnt   += int'(dmem_bus.dmem_req_o);
        rvld_cnt  += int'(rdata_valid_o);
        err_cnt   += int'(err_o);
        if (dmem_bus.dmem_req_o && !prev_req) rise_cnt++;
      end
      prev_req = dmem_bus.dmem_req_o;
    end
  end

  initial begin
    dmem_bus.dmem_ack_i = 0;
    dmem_bus.dmem_rdata_i = '0;

    // Reset state, then zero-wait load.
    reset_cycle(0, '0, 1);
    reset_cycle(0, '0, 1);
    idle(1);
    access(1, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
    idle(1);
    drain();
    chk("A_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("A_req_cycles", 32'(req_cnt), 32'd1);
    chk("A_rvld_pulses", 32'(rvld_cnt), 32'd1);
    chk("A_rdata", rdata_o, 32'hDEAD_BEEF);
    clr();

    // Store with three wait cycles.
    access(0, 32'h0000_0020, 32'h1234_5678, 3, 32'hFFFF_0000);
    idle(1);
    drain();
    chk("B_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("B_req_cycles", 32'(req_cnt), 32'd4);
    chk("B_rvld_pulses", 32'(rvld_cnt), 32'd0);
    chk("B_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    clr();

    // Misaligned load, then a stray ack while idle.
    begin
      cyc_t c;
      c = blank();
      c.en = 1; c.r = 1; c.addr = 32'h0000_0013;
      push(c);
      pend_err = 1;
      c = blank();
      push(c);
      c.ack = 1; c.rd = 32'h5555_5555;
      push(c);
      idle(1);
    end
    drain();
    chk("C_err_pulses", 32'(err_cnt), 32'd1);
    chk("C_stall_cycles", 32'(stall_cnt), 32'd0);
    chk("C_req_cycles", 32'(req_cnt), 32'd0);
    chk("C_rvld_pulses", 32'(rvld_cnt), 32'd0);
    clr();

    // Back-to-back zero-wait loads.
    access(1, 32'h0000_0004, 32'h0, 0, 32'h1111_1111);
    access(1, 32'h0000_0008, 32'h0, 0, 32'h2222_2222);
    idle(1);
    drain();
    chk("D_req_rises", 32'(rise_cnt), 32'd2);
    chk("D_rvld_pulses", 32'(rvld_cnt), 32'd2);
    chk("D_rdata", rdata_o, 32'h2222_2222);
    clr();

`ifdef MEM_TIMEOUT_EN
    access(1, 32'h0000_0030, 32'h0, -1, 32'h0);
    idle(1);
    drain();
    chk("E_req_cycles", 32'(req_cnt), 32'd16);
    chk("E_stall_cycles", 32'(stall_cnt), 32'd17);
    chk("E_err_pulses", 32'(err_cnt), 32'd1);
    chk("E_rdata_kept", rdata_o, 32'h2222_2222);
`else
    access(0, 32'h0000_0030, 32'hCAFE_F00D, 39, 32'h0);
    idle(1);
    drain();
    chk("E_req_cycles", 32'(req_cnt), 32'd40);
    chk("E_stall_cycles", 32'(stall_cnt), 32'd41);
    chk("E_err_pulses", 32'(err_cnt), 32'd0);
`endif
    clr();

    // Reset in the second REQ cycle, late ack one cycle later.
    begin
      cyc_t c;
      c = blank();
      c.en = 1; c.r = 1; c.addr = 32'h0000_0040;
      c.e_stall = 1;
      push(c);
      c.e_req = 1; c.bus_chk = 1; c.e_we = 0; c.e_addr = 32'h0000_0040; c.e_wdata = '0;
      push(c);
      reset_cycle(0, '0, 1);
      reset_cycle(1, 32'h7777_7777, 0);
      idle(2);
    end
    drain();
    chk("F_req_cycles", 32'(req_cnt), 32'd1);
    chk("F_rvld_pulses", 32'(rvld_cnt), 32'd0);
    chk("F_err_pulses", 32'(err_cnt), 32'd0);
    chk("F_rdata", rdata_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
